pattern_detect_scheduler: RTL

- Shares one "01" sequence-detector next-state datapath among NCH serial bit-stream channels.
- A round-robin arbiter selects one requesting channel per cycle. The selected channel's 2-bit detector state is loaded, advanced with its input bit, and written back.
- A Moore-style match is reported one cycle after the grant, tagged with the channel index.
- Sits between the serial front-end channels and the event-collection logic.

---
 rtl/pattern_pkg.sv | 23 ++
 rtl/pattern_detect_scheduler_if.sv | 39 +++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/pattern_detect_scheduler.sv | 93 +++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and next-state function for the "01" sequence detector.
package pattern_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } statetype;

    localparam statetype MATCH_STATE = S2;

    // 2'b11 is unreachable but decodes as S0 through the default arm.
    function automatic statetype pattern_next(statetype s, logic a);
        statetype n;
        case (s)
            S1:      n = a ? S2 : S1;
            S2:      n = a ? S0 : S1;
            default: n = a ? S0 : S1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pattern_detect_scheduler_if.sv
// Channel request/grant and match-report bundle for pattern_detect_scheduler.
// Counter select/readout signals exist only when PDS_MATCH_CNT_EN is defined.
interface pattern_detect_scheduler_if
    import pattern_pkg::*;
#(
    parameter int unsigned NCH = 4
);
    localparam int unsigned IDW = $clog2(NCH);

    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] ch_clr;
    logic [NCH-1:0] gnt;
    logic           match_valid;
    logic [IDW-1:0] match_ch;
`ifdef PDS_MATCH_CNT_EN
    logic [IDW-1:0] cnt_sel;
    logic [7:0]     cnt_out;
`endif

    modport master (
        output req, bit_in, ch_clr,
        input  gnt, match_valid, match_ch
`ifdef PDS_MATCH_CNT_EN
        , output cnt_sel
        , input  cnt_out
`endif
    );

    modport slave (
        input  req, bit_in, ch_clr,
        output gnt, match_valid, match_ch
`ifdef PDS_MATCH_CNT_EN
        , input  cnt_sel
        , output cnt_out
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating pointer.
module rr_arbiter
    import pattern_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  elig,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] rr_ptr;

    // Scan from rr_ptr upward, wrapping modulo N; first eligible channel wins.
    always_comb begin
        int unsigned   j;
        logic [IW-1:0] idx;
        j       = 0;
        idx     = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IW'(j);
            if (!gnt_any && !reset && elig[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Time-shares one "01" detector next-state datapath across NCH serial channels.
// Define PDS_MATCH_CNT_EN to add per-channel saturating match counters.
module pattern_detect_scheduler
    import pattern_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input logic                      clk,
    input logic                      reset,
    pattern_detect_scheduler_if.slave bus
);

    localparam int unsigned IDW = $clog2(NCH);

    statetype       chan_state [NCH];
    logic [NCH-1:0] elig;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    statetype       cur_state;
    statetype       nxt_state;
    logic           cur_bit;
    logic           match_valid;
    logic [IDW-1:0] match_ch;

    // A clearing channel is never granted, so clear always beats update.
    assign elig = bus.req & ~bus.ch_clr;

    rr_arbiter #(
        .N(NCH)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .elig   (elig),
        .gnt    (bus.gnt),
        .gnt_idx(gnt_idx),
        .gnt_any(gnt_any)
    );

    always_comb begin
        cur_state = chan_state[gnt_idx];
        cur_bit   = bus.bit_in[gnt_idx];
        nxt_state = pattern_next(cur_state, cur_bit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                chan_state[i] <= S0;
            end
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            match_valid <= gnt_any && (nxt_state == MATCH_STATE);
            if (gnt_any) begin
                match_ch <= gnt_idx;
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    chan_state[i] <= S0;
                end else if (gnt_any && gnt_idx == IDW'(i)) begin
                    chan_state[i] <= nxt_state;
                end
            end
        end
    end

    assign bus.match_valid = match_valid;
    assign bus.match_ch    = match_ch;

`ifdef PDS_MATCH_CNT_EN
    logic [7:0] match_cnt [NCH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                match_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    match_cnt[i] <= '0;
                end else if (match_valid && match_ch == IDW'(i) && match_cnt[i] != 8'hff) begin
                    match_cnt[i] <= match_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Out-of-range selects (NCH not a power of two) read as zero.
    assign bus.cnt_out = (32'(bus.cnt_sel) < NCH) ? match_cnt[bus.cnt_sel] : 8'd0;
`endif

endmodule
